car_odometer_bcd: RTL and testbench

//  Parametrised BCD odometer for the car simulation. Counts 2 ms tick cycles while the car

---
 rtl/car_odometer_bcd.sv | 101 ++++++++++
 tb/tb_car_odometer_bcd.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/car_odometer_bcd.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : car_odometer_bcd                                               |
// | Purpose  : Packed-BCD odometer; adds one unit per FWD/BWD tick period.     |
// |            Optional `ODO_SATURATE_EN holds at all-9s instead of wrapping.  |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module car_odometer_bcd #(
  parameter int DIGITS    = 4,
  parameter int FWD_TICKS = 46,
  parameter int BWD_TICKS = 92,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                move_forward,
  input  logic                move_backward,
  output logic [4*DIGITS-1:0] mile,
  output logic                mile_tick,
  output logic                rollover
);

  localparam logic [CNT_W-1:0] c_FWD_LAST = CNT_W'(FWD_TICKS - 1);
  localparam logic [CNT_W-1:0] c_BWD_LAST = CNT_W'(BWD_TICKS - 1);

  logic [CNT_W-1:0]    r_fwd_cnt;
  logic [CNT_W-1:0]    r_bwd_cnt;
  logic [4*DIGITS-1:0] r_mile;
  logic                r_tick;
  logic                r_rollover;

  logic [4*DIGITS-1:0] w_mile_inc;
  logic [DIGITS:0]     w_carry;
  logic                w_fwd_mode;
  logic                w_bwd_mode;
  logic                w_fwd_unit;
  logic                w_bwd_unit;
  logic                w_unit;
  logic                w_all_nines;

  // Opposing or absent move inputs both mean the car is stationary.
  assign w_fwd_mode = !clr && move_forward && !move_backward;
  assign w_bwd_mode = !clr && move_backward && !move_forward;
  assign w_fwd_unit = w_fwd_mode && (r_fwd_cnt == c_FWD_LAST);
  assign w_bwd_unit = w_bwd_mode && (r_bwd_cnt == c_BWD_LAST);
  assign w_unit     = w_fwd_unit || w_bwd_unit;

  // Ripple +1 from digit 0; a carry out of the top digit means the mileage was all 9s.
  assign w_carry[0] = 1'b1;
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_d;
      assign w_d                  = r_mile[4*g +: 4];
      assign w_carry[g+1]         = w_carry[g] && (w_d == 4'd9);
      assign w_mile_inc[4*g +: 4] = !w_carry[g]    ? w_d  :
                                    (w_d == 4'd9)  ? 4'd0 : w_d + 4'd1;
    end
  endgenerate
  assign w_all_nines = w_carry[DIGITS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fwd_cnt  <= '0;
      r_bwd_cnt  <= '0;
      r_mile     <= '0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else if (clr) begin
      r_fwd_cnt  <= '0;
      r_bwd_cnt  <= '0;
      r_mile     <= '0;
      r_tick     <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (w_fwd_mode) r_fwd_cnt <= w_fwd_unit ? '0 : r_fwd_cnt + 1'b1;
      if (w_bwd_mode) r_bwd_cnt <= w_bwd_unit ? '0 : r_bwd_cnt + 1'b1;
      if (w_unit) begin
`ifdef ODO_SATURATE_EN
        if (w_all_nines) begin
          r_rollover <= 1'b1;
        end else begin
          r_mile <= w_mile_inc;
          r_tick <= 1'b1;
        end
`else
        r_mile <= w_mile_inc;
        r_tick <= 1'b1;
        if (w_all_nines) r_rollover <= 1'b1;
`endif
      end
    end
  end

  assign mile      = r_mile;
  assign mile_tick = r_tick;
  assign rollover  = r_rollover;

endmodule
`default_nettype wire

// File: tb/tb_car_odometer_bcd.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_car_odometer_bcd                                            |
// | Purpose  : Scoreboard bench for car_odometer_bcd with a decimal model.     |
// | Revision : 1.0                                                            |
// +---------------------------------------------------------------------------+
module tb_car_odometer_bcd;

  localparam int DIGITS    = 3;
  localparam int FWD_TICKS = 4;
  localparam int BWD_TICKS = 7;
  localparam int CNT_W     = 3;
  localparam int MAXV      = 999;

  typedef struct packed {
    logic [4*DIGITS-1:0] mile;
    logic                tick;
    logic                roll;
  } exp_t;

  logic                clk;
  logic                reset;
  logic                clr;
  logic                move_forward;
  logic                move_backward;
  logic [4*DIGITS-1:0] mile;
  logic                mile_tick;
  logic                rollover;

  exp_t q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Decimal reference state
  int m_mile, m_fc, m_bc;
  bit m_tick, m_roll;

  car_odometer_bcd #(
    .DIGITS(DIGITS), .FWD_TICKS(FWD_TICKS), .BWD_TICKS(BWD_TICKS), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset(reset), .clr(clr),
    .move_forward(move_forward), .move_backward(move_backward),
    .mile(mile), .mile_tick(mile_tick), .rollover(rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int div;
    r   = '0;
    div = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got mile=%h tick=%b roll=%b, expected mile=%h tick=%b roll=%b",
               name, $time, act.mile, act.tick, act.roll, exp.mile, exp.tick, exp.roll);
    end
  endtask

  task automatic add_unit();
`ifdef ODO_SATURATE_EN
    if (m_mile == MAXV) begin
      m_roll = 1'b1;
    end else begin
      m_mile = m_mile + 1;
      m_tick = 1'b1;
    end
`else
    m_tick = 1'b1;
    if (m_mile == MAXV) m_roll = 1'b1;
    m_mile = (m_mile + 1) % (MAXV + 1);
`endif
  endtask

  task automatic model_step(input bit c, input bit f, input bit b);
    m_tick = 1'b0;
    if (c) begin
      m_mile = 0; m_fc = 0; m_bc = 0; m_roll = 1'b0;
    end else if (f && !b) begin
      m_fc = m_fc + 1;
      if (m_fc == FWD_TICKS) begin m_fc = 0; add_unit(); end
    end else if (b && !f) begin
      m_bc = m_bc + 1;
      if (m_bc == BWD_TICKS) begin m_bc = 0; add_unit(); end
    end
  endtask

  task automatic model_reset();
    m_mile = 0; m_fc = 0; m_bc = 0; m_tick = 1'b0; m_roll = 1'b0;
  endtask

  // One clock of stimulus; expectation is for the state after the next rising edge.
  task automatic drive(input bit c, input bit f, input bit b);
    @(posedge clk); #4;
    clr = c; move_forward = f; move_backward = b;
    model_step(c, f, b);
    q.push_back('{to_bcd(m_mile), m_tick, m_roll});
  endtask

  task automatic run(input bit c, input bit f, input bit b, input int n);
    for (int i = 0; i < n; i++) drive(c, f, b);
  endtask

  // Reset raised between edges must clear outputs before any further edge.
  task automatic async_reset();
    @(posedge clk); #4;
    reset = 1'b1;
    #1;
    check("async_reset", '{mile, mile_tick, rollover}, '{'0, 1'b0, 1'b0});
    @(posedge clk); #4;
    clr = 1'b0; move_forward = 1'b0; move_backward = 1'b0;
    reset = 1'b0;
    model_reset();
    model_step(1'b0, 1'b0, 1'b0);
    q.push_back('{to_bcd(m_mile), m_tick, m_roll});
  endtask

  // Monitor: every edge that has a pending expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("scoreboard", '{mile, mile_tick, rollover}, e);
      end
    end
  end

  initial begin
    int r;
    int len;
    reset = 1'b1; clr = 1'b0; move_forward = 1'b0; move_backward = 1'b0;
    model_reset();
    #1;
    check("reset_state", '{mile, mile_tick, rollover}, '{'0, 1'b0, 1'b0});
    @(posedge clk); #4;
    reset = 1'b0;
    model_step(1'b0, 1'b0, 1'b0);
    q.push_back('{to_bcd(m_mile), m_tick, m_roll});

    // First unit, then reach 10 units
    run(0, 1, 0, FWD_TICKS);
    run(0, 1, 0, FWD_TICKS * 9);
    // Backward partial count survives a hold
    run(0, 0, 1, BWD_TICKS - 1);
    run(0, 0, 0, 10);
    run(0, 0, 1, 1);
    // Both directions asserted is a hold
    run(0, 1, 1, 30);
    // clr with fwd while forward counter is on its last count
    run(1, 0, 0, 1);
    run(0, 1, 0, FWD_TICKS - 1);
    run(1, 1, 0, 1);
    run(0, 1, 0, FWD_TICKS);
    // Run forward through the all-9s boundary and beyond
    run(0, 1, 0, FWD_TICKS * (MAXV + 1));
    run(0, 1, 0, FWD_TICKS * 5);
    run(0, 0, 0, 3);
    // Asynchronous reset mid-count discards the partial count
    run(1, 0, 0, 1);
    run(0, 1, 0, FWD_TICKS * 123 + 2);
    async_reset();
    run(0, 1, 0, FWD_TICKS);

    // Randomized traffic
    for (int s = 0; s < 400; s++) begin
      r   = $urandom_range(0, 99);
      len = $urandom_range(1, 25);
      if (s == 200)     async_reset();
      else if (r < 1)   run(1, $urandom_range(0, 1), $urandom_range(0, 1), 1);
      else if (r < 55)  run(0, 1, 0, len);
      else if (r < 80)  run(0, 0, 1, len);
      else if (r < 90)  run(0, 0, 0, len);
      else              run(0, 1, 1, len);
    end

    repeat (3) @(posedge clk);
    #3;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
